// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared QPSK definitions.
//   PH_0..PH_3        quarter-period phase indices
//   DEFAULT_CARRIER_W default carrier counter width
//   bit_phase_e       serial bit-pairing state (I expected / Q expected)
//   gray_phase()      Gray dibit {I,Q} to phase index, also inverted by the demodulator
package qpsk_pkg;

   localparam logic [1:0] PH_0 = 2'd0;
   localparam logic [1:0] PH_1 = 2'd1;
   localparam logic [1:0] PH_2 = 2'd2;
   localparam logic [1:0] PH_3 = 2'd3;

   localparam int unsigned DEFAULT_CARRIER_W = 2;

   typedef enum logic {
      EXPECT_I = 1'b0,
      EXPECT_Q = 1'b1
   } bit_phase_e;

   // Adjacent phases differ in one bit: 00->0, 01->1, 11->2, 10->3
   function automatic logic [1:0] gray_phase(input logic i_b, input logic q_b);
      logic [1:0] ph;
      case ({i_b, q_b})
         2'b00:   ph = PH_0;
         2'b01:   ph = PH_1;
         2'b11:   ph = PH_2;
         default: ph = PH_3;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/qpsk_serial_mapper_if.sv
// qpsk_serial_mapper_if: serial-bit input and symbol/carrier outputs of the mapper.
//   en, data, load          : from the data source (master drives)
//   i_bit, q_bit, phase_sel : last committed dibit and its phase index
//   sym_valid               : one-clock commit pulse
//   active, qpsk_out        : carrier enabled flag and square-wave output
interface qpsk_serial_mapper_if;
   logic       en;
   logic       data;
   logic       load;
   logic       i_bit;
   logic       q_bit;
   logic [1:0] phase_sel;
   logic       sym_valid;
   logic       active;
   logic       qpsk_out;

   modport master (
      output en, data, load,
      input  i_bit, q_bit, phase_sel, sym_valid, active, qpsk_out
   );

   modport slave (
      input  en, data, load,
      output i_bit, q_bit, phase_sel, sym_valid, active, qpsk_out
   );
endinterface

// File: rtl/qpsk_carrier_nco.sv
// qpsk_carrier_nco: free-running carrier counter with quarter-period phase offset.
//   clk, rst   : clock, asynchronous active-low reset
//   en         : count enable; output register also holds while low
//   active     : gates the output to 0 until the first symbol exists
//   phase_sel  : phase index in quarter periods
//   qpsk_out   : registered MSB of (counter + phase offset)
module qpsk_carrier_nco
   import qpsk_pkg::*;
#(
   parameter int unsigned CARRIER_W = DEFAULT_CARRIER_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       active,
   input  logic [1:0] phase_sel,
   output logic       qpsk_out
);

   logic [CARRIER_W-1:0] count_q;
   logic [CARRIER_W-1:0] offset;
   logic [CARRIER_W-1:0] shifted;

   // One phase step is a quarter period, i.e. phase_sel scaled by 2^(CARRIER_W-2);
   // the sum wraps naturally at the counter width.
   always_comb begin
      offset  = CARRIER_W'(phase_sel) << (CARRIER_W - 2);
      shifted = count_q + offset;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= '0;
         qpsk_out <= 1'b0;
      end else if (en) begin
         count_q  <= count_q + CARRIER_W'(1);
         qpsk_out <= active & shifted[CARRIER_W-1];
      end
   end

endmodule

// File: rtl/qpsk_serial_mapper.sv
// qpsk_serial_mapper: pairs serial bits into dibits (I first, Q second), maps each
// dibit to a carrier phase and drives a phase-shifted square-wave QPSK output.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of qpsk_serial_mapper_if (en/data/load in, symbol and carrier out)
// Parameters: CARRIER_W (carrier period 2^CARRIER_W clocks, >= 2),
//             MAP_GRAY (1 = Gray phase map, 0 = {I,Q} used directly).
module qpsk_serial_mapper
   import qpsk_pkg::*;
#(
   parameter int unsigned CARRIER_W = DEFAULT_CARRIER_W,
   parameter bit          MAP_GRAY  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   qpsk_serial_mapper_if.slave  bus
);

   bit_phase_e state_q, state_d;
   logic       i_hold_q, i_hold_d;
   logic       i_bit_q, i_bit_d;
   logic       q_bit_q, q_bit_d;
   logic [1:0] phase_q, phase_d;
   logic       sym_valid_q, sym_valid_d;
   logic       active_q, active_d;
   logic       nco_out;

   function automatic logic [1:0] map_phase(input logic i_b, input logic q_b);
      return MAP_GRAY ? gray_phase(i_b, q_b) : {i_b, q_b};
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EXPECT_I;
         i_hold_q    <= 1'b0;
         i_bit_q     <= 1'b0;
         q_bit_q     <= 1'b0;
         phase_q     <= PH_0;
         sym_valid_q <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_hold_q    <= i_hold_d;
         i_bit_q     <= i_bit_d;
         q_bit_q     <= q_bit_d;
         phase_q     <= phase_d;
         sym_valid_q <= sym_valid_d;
         active_q    <= active_d;
      end
   end

   // sym_valid is rebuilt every edge (so it drops even while en is low);
   // everything else only moves on an accepted bit.
   always_comb begin
      state_d     = state_q;
      i_hold_d    = i_hold_q;
      i_bit_d     = i_bit_q;
      q_bit_d     = q_bit_q;
      phase_d     = phase_q;
      sym_valid_d = 1'b0;
      active_d    = active_q;
      if (bus.en && bus.load) begin
         case (state_q)
            EXPECT_I: begin
               i_hold_d = bus.data;
               state_d  = EXPECT_Q;
            end
            EXPECT_Q: begin
               i_bit_d     = i_hold_q;
               q_bit_d     = bus.data;
               phase_d     = map_phase(i_hold_q, bus.data);
               sym_valid_d = 1'b1;
               active_d    = 1'b1;
               state_d     = EXPECT_I;
            end
            default: state_d = EXPECT_I;
         endcase
      end
   end

   qpsk_carrier_nco #(
      .CARRIER_W (CARRIER_W)
   ) u_nco (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en),
      .active    (active_q),
      .phase_sel (phase_q),
      .qpsk_out  (nco_out)
   );

   assign bus.i_bit     = i_bit_q;
   assign bus.q_bit     = q_bit_q;
   assign bus.phase_sel = phase_q;
   assign bus.sym_valid = sym_valid_q;
   assign bus.active    = active_q;
   assign bus.qpsk_out  = nco_out;

endmodule
